mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 14 +
 rtl/mem_arb_prio.sv | 42 ++++
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory subsystem.
// Owner encoding identifies which requester the next SRAM response belongs to.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select between fetch and data requesters with a starvation guard:
// dmem normally wins, but imem is forced through after STARVE_LIMIT straight losses.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_valid,
  input  logic       dmem_valid,
  output logic       grant_imem,
  output logic       grant_dmem,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Grants are forced low while reset is held so no access leaks out.
  always_comb begin
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if (rst_n) begin
      if (imem_valid && (!dmem_valid || starve_cnt == LIMIT)) begin
        grant_imem = 1'b1;
      end else if (dmem_valid) begin
        grant_dmem = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (imem_valid && grant_dmem) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter for instruction fetch and data accesses.
// One grant per cycle; the response returns exactly one cycle later on the owner's port.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_SIZE     = 4096,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(MEM_SIZE) - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_valid_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_ready_o,
  output logic              imem_rvalid_o,
  output logic [XLEN-1:0]   imem_rdata_o,
  input  logic              dmem_valid_i,
  input  logic              dmem_we_i,
  input  logic [3:0]        dmem_be_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [XLEN-1:0]   dmem_wdata_i,
  output logic              dmem_ready_o,
  output logic              dmem_rvalid_o,
  output logic [XLEN-1:0]   dmem_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  logic       grant_imem;
  logic       grant_dmem;
  logic [3:0] starve_cnt;

  owner_e owner_q, owner_d;
  logic   wr_q, wr_d;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_valid(imem_valid_i),
    .dmem_valid(dmem_valid_i),
    .grant_imem(grant_imem),
    .grant_dmem(grant_dmem),
    .starve_cnt(starve_cnt)
  );

  // Address bits outside the SRAM window are ignored, so accesses wrap.
  logic unused_ok;
  assign unused_ok = ^{imem_addr_i[ADDR_W-1:AW+2], imem_addr_i[1:0],
                       dmem_addr_i[ADDR_W-1:AW+2], dmem_addr_i[1:0], starve_cnt};

  assign imem_ready_o = grant_imem;
  assign dmem_ready_o = grant_dmem;
  assign mem_en_o     = grant_imem | grant_dmem;
  assign mem_addr_o   = grant_dmem ? dmem_addr_i[AW+1:2] : imem_addr_i[AW+1:2];
  assign mem_we_o     = (grant_dmem && dmem_we_i) ? dmem_be_i : 4'b0000;
  assign mem_wdata_o  = dmem_wdata_i;

  // Owner of the response due next cycle; NONE whenever nothing was granted.
  always_comb begin
    owner_d = OWN_NONE;
    wr_d    = 1'b0;
    if (grant_imem) begin
      owner_d = OWN_IMEM;
    end else if (grant_dmem) begin
      owner_d = OWN_DMEM;
      wr_d    = dmem_we_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      wr_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
    end
  end

  assign imem_rvalid_o = (owner_q == OWN_IMEM);
  assign dmem_rvalid_o = (owner_q == OWN_DMEM);
  assign imem_rdata_o  = (owner_q == OWN_IMEM) ? mem_rdata_i : '0;
  assign dmem_rdata_o  = (owner_q == OWN_DMEM && !wr_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a word-array reference model.
// Driver predicts grants and pushes expected responses; a monitor pops on rvalid.
module tb_mem_arbiter;

  localparam int MEM_SIZE     = 4096;
  localparam int STARVE_LIMIT = 4;
  localparam int AW           = $clog2(MEM_SIZE) - 2;
  localparam int WORDS        = MEM_SIZE / 4;

  logic          clk;
  logic          rst_n;
  logic          imem_valid_i;
  logic [31:0]   imem_addr_i;
  logic          imem_ready_o;
  logic          imem_rvalid_o;
  logic [31:0]   imem_rdata_o;
  logic          dmem_valid_i;
  logic          dmem_we_i;
  logic [3:0]    dmem_be_i;
  logic [31:0]   dmem_addr_i;
  logic [31:0]   dmem_wdata_i;
  logic          dmem_ready_o;
  logic          dmem_rvalid_o;
  logic [31:0]   dmem_rdata_o;
  logic          mem_en_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  mem_arbiter #(
    .MEM_SIZE    (MEM_SIZE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_valid_i (imem_valid_i),
    .imem_addr_i  (imem_addr_i),
    .imem_ready_o (imem_ready_o),
    .imem_rvalid_o(imem_rvalid_o),
    .imem_rdata_o (imem_rdata_o),
    .dmem_valid_i (dmem_valid_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_be_i    (dmem_be_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_ready_o (dmem_ready_o),
    .dmem_rvalid_o(dmem_rvalid_o),
    .dmem_rdata_o (dmem_rdata_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM device model ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (i * 32'h9E3779B9) + 32'h0123_4567;
  endfunction

  logic [31:0] sram [WORDS];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= init_word(i);
    end else if (mem_en_o) begin
      mem_rdata_i <= sram[mem_addr_o];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          icq[$];
  int          dcq[$];

  logic [31:0] ref_mem [WORDS];
  int          starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a % MEM_SIZE) / 4);
  endfunction

  task automatic ref_init();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; presents one cycle of requests, predicts the grant,
  // checks the combinational outputs and records the expected response.
  task automatic drive_cycle(input logic iv, input logic [31:0] ia,
                             input logic dv, input logic dwe, input logic [3:0] dbe,
                             input logic [31:0] da, input logic [31:0] dwd,
                             output logic gi, output logic gd, output logic act_i);
    int wa;
    imem_valid_i = iv;  imem_addr_i = ia;
    dmem_valid_i = dv;  dmem_we_i = dwe;  dmem_be_i = dbe;
    dmem_addr_i  = da;  dmem_wdata_i = dwd;
    #1;
    gi = iv && (!dv || starve >= STARVE_LIMIT);
    gd = dv && !gi;
    act_i = imem_ready_o;
    chk("imem_ready", 32'(imem_ready_o), 32'(gi));
    chk("dmem_ready", 32'(dmem_ready_o), 32'(gd));
    chk("mem_en", 32'(mem_en_o), 32'(gi | gd));
    if (gi || gd) begin
      wa = word_of(gi ? ia : da);
      chk("mem_addr", 32'(mem_addr_o), 32'(wa));
      chk("mem_we", 32'(mem_we_o), (gd && dwe) ? 32'(dbe) : 32'h0);
      if (gd && dwe) chk("mem_wdata", mem_wdata_o, dwd);
      if (gi) begin
        iq.push_back(ref_mem[wa]);
        icq.push_back(cyc);
      end else begin
        dq.push_back(dwe ? 32'h0 : ref_mem[wa]);
        dcq.push_back(cyc);
        if (dwe)
          for (int b = 0; b < 4; b++)
            if (dbe[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
      end
    end else begin
      chk("mem_we_idle", 32'(mem_we_o), 32'h0);
    end
    if (iv && gd) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
    else          starve = 0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_imem_ready"}, 32'(imem_ready_o), 32'h0);
    chk({tag, "_dmem_ready"}, 32'(dmem_ready_o), 32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en_o), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, "_imem_rvalid"}, 32'(imem_rvalid_o), 32'h0);
    chk({tag, "_dmem_rvalid"}, 32'(dmem_rvalid_o), 32'h0);
    chk({tag, "_imem_rdata"}, imem_rdata_o, 32'h0);
    chk({tag, "_dmem_rdata"}, dmem_rdata_o, 32'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    int          c;
    forever begin
      @(negedge clk);
      #1;
      if (icq.size() > 0 && icq[0] + 1 < cyc) begin
        chk("imem_missing_rvalid", 32'h0, 32'h1);
        void'(iq.pop_front());
        void'(icq.pop_front());
      end
      if (dcq.size() > 0 && dcq[0] + 1 < cyc) begin
        chk("dmem_missing_rvalid", 32'h0, 32'h1);
        void'(dq.pop_front());
        void'(dcq.pop_front());
      end
      if (imem_rvalid_o) begin
        if (iq.size() == 0) chk("imem_spurious_rvalid", 32'h1, 32'h0);
        else begin
          e = iq.pop_front();
          c = icq.pop_front();
          chk("imem_rdata", imem_rdata_o, e);
          chk("imem_latency", 32'(cyc), 32'(c + 1));
        end
      end else begin
        chk("imem_rdata_idle", imem_rdata_o, 32'h0);
      end
      if (dmem_rvalid_o) begin
        if (dq.size() == 0) chk("dmem_spurious_rvalid", 32'h1, 32'h0);
        else begin
          e = dq.pop_front();
          c = dcq.pop_front();
          chk("dmem_rdata", dmem_rdata_o, e);
          chk("dmem_latency", 32'(cyc), 32'(c + 1));
        end
      end else begin
        chk("dmem_rdata_idle", dmem_rdata_o, 32'h0);
      end
      if (imem_rvalid_o && dmem_rvalid_o) chk("both_rvalid", 32'h1, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        gi, gd, ai;
    logic        ip, dp, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;

    rst_n = 1'b0;
    imem_valid_i = 1'b1;  imem_addr_i = 32'h0;
    dmem_valid_i = 1'b1;  dmem_we_i = 1'b1;  dmem_be_i = 4'hF;
    dmem_addr_i  = 32'h0; dmem_wdata_i = 32'h0;
    ref_init();
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch of word 4 preloaded with DEADBEEF.
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);
    // Partial write then read back the merged word.
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234_5678, gi, gd, ai);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, gi, gd, ai);
    // Address beyond MEM_SIZE wraps to word 1.
    drive_cycle(1'b1, 32'h1004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);

    // Both requesting every cycle: D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, $urandom, 32'h0, gi, gd, ai);
      chk("starve_pattern", 32'(ai), 32'((k % 5) == 4));
    end

    // Alternating single requests: one grant and one response every cycle.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        drive_cycle(1'b1, $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);
      else
        drive_cycle(1'b0, 32'h0, 1'b1, 1'(k % 4 == 1), 4'(k), $urandom, $urandom, gi, gd, ai);
    end

    // Random traffic; requesters hold their request until granted.
    ip = 1'b0; dp = 1'b0; ia = 0; da = 0; dwd = 0; dwe = 0; dbe = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin
        ip = 1'b1;
        ia = (k % 3 == 0) ? $urandom : 32'($urandom_range(0, 63));
      end
      if (!dp && $urandom_range(0, 99) < 60) begin
        dp  = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15));
        da  = (k % 3 == 1) ? $urandom : 32'($urandom_range(0, 63));
        dwd = $urandom;
      end
      drive_cycle(ip, ia, dp, dwe, dbe, da, dwd, gi, gd, ai);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end

    // Reset in the cycle after a grant drops the pending response.
    imem_valid_i = 1'b1; imem_addr_i = 32'h20;
    dmem_valid_i = 1'b0;
    #1;
    chk("pre_reset_grant", 32'(imem_ready_o), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    iq.delete(); icq.delete(); dq.delete(); dcq.delete();
    starve = 0;
    ref_init();
    dmem_valid_i = 1'b1;
    @(negedge clk);
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);
    chk("post_reset_first_grant", 32'(ai), 32'h1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd, ai);

    repeat (3) @(negedge clk);
    #2;
    chk("imem_queue_drained", 32'(iq.size()), 32'h0);
    chk("dmem_queue_drained", 32'(dq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
